// File: rtl/triwave_pkg.sv
// Shared types and defaults for the triangular-wave sequencer.
// The FSM states and the default sizes used by the controller and its prescaler live here.
package triwave_pkg;

    localparam int          CW_DEF      = 12;
    localparam int          DIVW_DEF    = 16;
    localparam int          PCW_DEF     = 16;
    localparam logic [11:0] BOT_VAL_DEF = 12'h802;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // The generator is stepped and watched only in these states.
    function automatic logic is_active(input state_e s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/triwave_seq_ctrl_tick_prescaler.sv
// Free-running divide-by-(div+1) tick source.
// clr restarts the count; the count holds whenever run is low.
module tick_prescaler
    import triwave_pkg::*;
#(
    parameter int DIVW = DIVW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            run,
    input  logic [DIVW-1:0] div,
    output logic            tick
);

    logic [DIVW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        tick  = run && (cnt_q == div);
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + DIVW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/triwave_seq_ctrl.sv
// Burst sequencer for the 12-bit triangular-wave generator: clears it at burst start,
// strobes its enable at a prescaled rate and counts wave periods at the bottom turning point.
module triwave_seq_ctrl
    import triwave_pkg::*;
#(
    parameter int             CW      = CW_DEF,
    parameter int             DIVW    = DIVW_DEF,
    parameter int             PCW     = PCW_DEF,
    parameter logic [CW-1:0]  BOT_VAL = BOT_VAL_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [DIVW-1:0] cfg_div,
    input  logic [PCW-1:0]  cfg_periods,
    input  logic            stop,
    input  logic            abort,
    input  logic [CW-1:0]   gen_count,
    output logic            gen_en,
    output logic            gen_clr_n,
    output logic            busy,
    output logic            done,
    output logic [PCW-1:0]  period_cnt
);

    state_e          state_q, state_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [PCW-1:0]  periods_q, periods_d;
    logic [PCW-1:0]  period_cnt_q, period_cnt_d;
    logic [CW-1:0]   prev_count_q;
    logic            gen_en_q, gen_en_d;

    logic            xfer;
    logic            active;
    logic            boundary;
    logic            last_period;
    logic            tick;
    logic [PCW-1:0]  pc_inc;

    assign xfer        = cfg_valid && (state_q == IDLE);
    assign active      = is_active(state_q);
    // Edge-detect the arrival at BOT_VAL so a frozen generator is not counted twice.
    assign boundary    = active && (gen_count == BOT_VAL) && (prev_count_q != BOT_VAL);
    assign pc_inc      = period_cnt_q + PCW'(1);
    assign last_period = (periods_q != '0) && (pc_inc == periods_q);

    tick_prescaler #(
        .DIVW (DIVW)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (xfer),
        .run   (active),
        .div   (div_q),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            div_q        <= '0;
            periods_q    <= '0;
            period_cnt_q <= '0;
            prev_count_q <= '0;
            gen_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            periods_q    <= periods_d;
            period_cnt_q <= period_cnt_d;
            prev_count_q <= gen_count;
            gen_en_q     <= gen_en_d;
        end
    end

    // Priority inside a burst: abort, then terminating boundary, then stop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (xfer) state_d = CLEAR;
            CLEAR: state_d = abort ? IDLE : RUN;
            RUN: begin
                if (abort)                        state_d = IDLE;
                else if (boundary && last_period) state_d = DONE;
                else if (stop)                    state_d = DRAIN;
            end
            DRAIN: begin
                if (abort)         state_d = IDLE;
                else if (boundary) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d        = div_q;
        periods_d    = periods_q;
        period_cnt_d = period_cnt_q;
        if (xfer) begin
            div_d        = cfg_div;
            periods_d    = cfg_periods;
            period_cnt_d = '0;
        end else if (boundary && !abort) begin
            period_cnt_d = pc_inc;
        end
        // Gating on the next state keeps the strobe low in DONE and right after an abort.
        gen_en_d = tick && is_active(state_d);
    end

    always_comb begin
        cfg_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        gen_clr_n  = (state_q != CLEAR);
        done       = (state_q == DONE);
        gen_en     = gen_en_q;
        period_cnt = period_cnt_q;
    end

endmodule

// File: tb/tb_triwave_seq_ctrl.sv
// Directed bench for triwave_seq_ctrl driving a small triangle generator model (0x802..0x806).
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_triwave_seq_ctrl;

    localparam logic [11:0] BOT     = 12'h802;
    localparam logic [11:0] TOP     = 12'h806;
    localparam logic [11:0] CLR_VAL = 12'h804;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_div;
    logic [15:0] cfg_periods;
    logic        stop;
    logic        abort;
    logic [11:0] gen_count;
    logic        gen_en;
    logic        gen_clr_n;
    logic        busy;
    logic        done;
    logic [15:0] period_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int en_cnt, done_cnt, done_at, idle_at, first_en_at, last_en_at, min_gap, max_gap;
    logic [15:0] pc_log[$];
    int spurious;

    triwave_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_div     (cfg_div),
        .cfg_periods (cfg_periods),
        .stop        (stop),
        .abort       (abort),
        .gen_count   (gen_count),
        .gen_en      (gen_en),
        .gen_clr_n   (gen_clr_n),
        .busy        (busy),
        .done        (done),
        .period_cnt  (period_cnt)
    );

    always #42 clk = ~clk;

    // Triangle generator: clear loads 0x804 counting up; 6 enables to the first bottom, 8 per period after.
    logic gen_up;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_count <= CLR_VAL;
            gen_up    <= 1'b1;
        end else if (!gen_clr_n) begin
            gen_count <= CLR_VAL;
            gen_up    <= 1'b1;
        end else if (gen_en) begin
            if (gen_up) begin
                if (gen_count == TOP) begin
                    gen_up    <= 1'b0;
                    gen_count <= gen_count - 12'd1;
                end else begin
                    gen_count <= gen_count + 12'd1;
                end
            end else begin
                if (gen_count == BOT) begin
                    gen_up    <= 1'b1;
                    gen_count <= gen_count + 12'd1;
                end else begin
                    gen_count <= gen_count - 12'd1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic accept(input logic [15:0] div, input logic [15:0] per);
        cfg_div     = div;
        cfg_periods = per;
        cfg_valid   = 1'b1;
        step();
        cfg_valid   = 1'b0;
    endtask

    task automatic wait_pc(input logic [15:0] v, input int max, input string tag);
        for (int i = 0; i < max && period_cnt != v; i++) step();
        check(tag, period_cnt, v);
    endtask

    task automatic wait_bot(input int max, input string tag);
        for (int i = 0; i < max && gen_count != BOT; i++) step();
        check(tag, gen_count, BOT);
    endtask

    // Steps until busy drops (or the budget runs out) and records strobe/done/count activity.
    task automatic watch(input int max_cyc);
        logic [15:0] last_pc;
        en_cnt      = 0;
        done_cnt    = 0;
        done_at     = -1;
        idle_at     = -1;
        first_en_at = -1;
        last_en_at  = -1;
        min_gap     = 9999;
        max_gap     = 0;
        pc_log.delete();
        last_pc = period_cnt;
        for (int i = 1; i <= max_cyc; i++) begin
            step();
            if (gen_en) begin
                en_cnt++;
                if (first_en_at < 0) first_en_at = i;
                if (last_en_at >= 0) begin
                    if (i - last_en_at < min_gap) min_gap = i - last_en_at;
                    if (i - last_en_at > max_gap) max_gap = i - last_en_at;
                end
                last_en_at = i;
            end
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            if (period_cnt != last_pc) begin
                pc_log.push_back(period_cnt);
                last_pc = period_cnt;
            end
            if (!busy) begin
                idle_at = i;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_div     = '0;
        cfg_periods = '0;
        stop        = 1'b0;
        abort       = 1'b0;

        // Reset values
        #10;
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_gen_en", gen_en, 0);
        check("rst_gen_clr_n", gen_clr_n, 1);
        check("rst_period_cnt", period_cnt, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Pairing: div=0, two periods
        accept(16'd0, 16'd2);
        check("p_clr_low", gen_clr_n, 0);
        check("p_busy", busy, 1);
        check("p_cfg_ready", cfg_ready, 0);
        step();
        check("p_clr_one_cycle", gen_clr_n, 1);
        watch(60);
        check("p_pc_steps", pc_log.size(), 2);
        check("p_pc_first", (pc_log.size() > 0) ? pc_log[0] : 16'hFFFF, 1);
        check("p_pc_second", (pc_log.size() > 1) ? pc_log[1] : 16'hFFFF, 2);
        check("p_done_once", done_cnt, 1);
        check("p_done_at", done_at, 16);
        check("p_busy_after_done", idle_at - done_at, 1);
        check("p_en_count", en_cnt, 15);
        check("p_min_gap", min_gap, 1);
        check("p_final_pc", period_cnt, 2);

        // Prescaler div=3; cfg_valid held while busy must not disturb the latched config
        accept(16'd3, 16'd1);
        cfg_valid   = 1'b1;
        cfg_div     = 16'd0;
        cfg_periods = 16'd5;
        step();
        watch(80);
        cfg_valid = 1'b0;
        check("d_first_en", first_en_at, 4);
        check("d_min_gap", min_gap, 4);
        check("d_max_gap", max_gap, 4);
        check("d_en_count", en_cnt, 6);
        check("d_done_once", done_cnt, 1);
        check("d_final_pc", period_cnt, 1);
        check("d_idle_reached", idle_at, 27);
        step();
        check("d_no_retrigger", busy, 0);

        // Continuous mode, graceful stop after five periods
        accept(16'd0, 16'd0);
        step();
        wait_pc(16'd5, 80, "s_reach_5");
        step();
        step();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("s_drain_busy", busy, 1);
        check("s_drain_no_done", done, 0);
        check("s_drain_en", gen_en, 1);
        check("s_drain_pc", period_cnt, 5);
        watch(40);
        check("s_pc_log", pc_log.size(), 1);
        check("s_final_pc", period_cnt, 6);
        check("s_done_once", done_cnt, 1);
        check("s_busy_after_done", idle_at - done_at, 1);

        // Abort during RUN after one period
        accept(16'd0, 16'd0);
        step();
        wait_pc(16'd1, 30, "a_reach_1");
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("a_gen_en", gen_en, 0);
        check("a_cfg_ready", cfg_ready, 1);
        check("a_no_done", done, 0);
        check("a_pc_hold", period_cnt, 1);
        step();
        check("a_no_done_late", done, 0);
        check("a_pc_hold_late", period_cnt, 1);
        accept(16'd0, 16'd1);
        check("a_new_pc_zero", period_cnt, 0);
        step();
        watch(40);
        check("a_new_done", done_cnt, 1);
        check("a_new_pc", period_cnt, 1);

        // Stop on the same cycle as the terminating boundary
        accept(16'd0, 16'd1);
        step();
        wait_bot(30, "c_reach_bot");
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("c_done", done, 1);
        check("c_pc", period_cnt, 1);
        step();
        check("c_done_single", done, 0);
        check("c_idle", busy, 0);
        check("c_cfg_ready", cfg_ready, 1);

        // Asynchronous reset while draining
        accept(16'd0, 16'd0);
        step();
        wait_pc(16'd1, 30, "r_reach_1");
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("r_drain_busy", busy, 1);
        check("r_drain_en", gen_en, 1);
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        check("r_busy", busy, 0);
        check("r_gen_en", gen_en, 0);
        check("r_pc", period_cnt, 0);
        check("r_done", done, 0);
        check("r_cfg_ready", cfg_ready, 1);
        check("r_gen_clr_n", gen_clr_n, 1);
        step();
        step();
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done || busy) spurious++;
        end
        check("r_no_spurious", spurious, 0);
        check("r_ready_after", cfg_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/triwave_seq_ctrl.md
Name: triwave_seq_ctrl

Overview:
Sequencer for the 12-bit triangular-wave generator. It accepts a burst configuration over a valid/ready handshake and clears the generator at burst start. It strobes the generator enable at a programmable prescaled rate and counts completed wave periods by watching the generator's count. It ends the burst on period count, graceful stop or immediate abort, then reports done.

Parameters:
CW, 12, generator count width
DIVW, 16, prescaler divisor width
PCW, 16, period counter width
BOT_VAL, 12'h802, generator count value marking the period boundary

Ports:
clk  in  1  system clock (12 MHz)
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  burst configuration valid
cfg_ready  out  1  controller can accept configuration; high only in IDLE
cfg_div  in  DIVW  prescaler divisor; tick every cfg_div+1 clocks
cfg_periods  in  PCW  periods in burst; 0 = continuous until stop/abort
stop  in  1  graceful stop: finish current period, then done
abort  in  1  immediate stop, no done pulse
gen_count  in  CW  generator count output
gen_en  out  1  one-cycle enable strobe to generator
gen_clr_n  out  1  active-low clear to generator
busy  out  1  high from accept until return to IDLE
done  out  1  one-cycle pulse at burst end (not on abort)
period_cnt  out  PCW  periods completed in current/last burst

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gen_en=0, gen_clr_n=1, busy=0, done=0, period_cnt=0; prescaler=0; latched cfg=0; stop_pend=0.
- Handshake: transfer on cfg_valid & cfg_ready. cfg_ready = (state==IDLE). cfg_div and cfg_periods are latched on transfer. cfg_valid outside IDLE is ignored, with no side effects.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE -> CLEAR on transfer. In the same edge, period_cnt<=0 and prescaler<=0.
- CLEAR lasts one cycle: gen_clr_n=0, busy=1. Then -> RUN.
- RUN: the prescaler counts 0..div. tick=1 when prescaler==div, and the prescaler then reloads 0. gen_en=tick, registered, so it appears one cycle after the tick condition.
- Period boundary: gen_count==BOT_VAL while the registered previous gen_count != BOT_VAL. On a boundary, period_cnt increments. It wraps in continuous mode and never exceeds cfg_periods otherwise.
- RUN -> DONE when a boundary brings period_cnt to cfg_periods (cfg_periods != 0).
- RUN -> DRAIN when stop is sampled high. DRAIN keeps ticking; on the next boundary it counts it and goes -> DONE.
- stop in the same cycle as a terminating boundary -> DONE; stop is consumed.
- DONE lasts one cycle: done=1, gen_en=0. Then -> IDLE. busy drops in IDLE.
- abort in CLEAR/RUN/DRAIN: next state IDLE, gen_en=0 next cycle, no done, period_cnt holds. abort beats stop and completion in the same cycle. abort/stop in IDLE or DONE are ignored.
- Reset mid-burst: immediate return to reset values. The generator is not cleared by this block during reset.
- Generator hold: gen_en=0 in IDLE/CLEAR/DONE, so the generator freezes at its last value.
- Arithmetic: the prescaler compare is unsigned DIVW-bit. cfg_div=0 gives a tick every clock.

Decomposition:
- Package triwave_pkg: state enum (IDLE, CLEAR, RUN, DRAIN, DONE), default BOT_VAL, default widths.
- Sub-module tick_prescaler, natural split: inputs clk, rst_n, clr, run, div. Output tick. It has an internal counter.

Test Plan:
- Pairing: pair with the real generator. Config cfg_div=0, cfg_periods=2 -> gen_clr_n low exactly 1 cycle after accept; gen_en high every cycle in RUN; period_cnt steps 1 then 2; done pulses once; busy falls the cycle after done.
- Prescaler: cfg_div=3 -> gen_en pulses exactly every 4 clocks, first pulse 4 clocks after entering RUN, never two consecutive.
- Continuous stop: cfg_periods=0; assert stop mid-period after period_cnt=5 -> state DRAIN; generator keeps running until the next BOT_VAL; period_cnt=6; done=1.
- Abort: abort during RUN with period_cnt=1 -> gen_en=0 next cycle, no done, cfg_ready=1, period_cnt stays 1. A new cfg transfer then resets period_cnt to 0.
- Collision: stop asserted on the same cycle as the terminating boundary (cfg_periods=1) -> single done, no DRAIN visit. cfg_valid asserted while busy -> ignored, latched div unchanged.
- Async reset: assert rst_n low mid-DRAIN, asynchronous to clk -> all outputs at reset values immediately. After release, cfg_ready=1 and no spurious done.
